pipe_stage_buf: RTL and testbench

Parametrised elastic buffer placed between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V core, replacing the fixed single-entry stage registers. It carries an opaque payload of WIDTH bits, normally one of the stage structs, with a valid/ready handshake on each side, a synchronous flush for branch and jump squash, and DEPTH entries of buffering so that a downstream stall does not have to propagate combinationally upstream. An optional counter records stall cycles for performance analysis.

---
 rtl/pipe_stage_buf_pkg.sv | 6 +
 rtl/pipe_stage_buf_ptr.sv | 16 +
 rtl/pipe_stage_buf.sv | 53 +++++
 tb/tb_pipe_stage_buf.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared pipeline constants and types used by the stage buffers.
package pipe_stage_buf_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int BUF_DEPTH_MAX = 4;
  typedef enum logic [1:0] {IF_ID, ID_EX, EX_MEM, MEM_WB} stage_id_e;
endpackage

// File: rtl/pipe_stage_buf_ptr.sv
// pipe_stage_buf_ptr: circular pointer that wraps at DEPTH-1 by explicit compare, with clear and increment.
module pipe_stage_buf_ptr #(
  parameter int DEPTH = 2,
  parameter int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry elastic buffer between pipeline stages with valid/ready and flush.
// Optional saturating stall counter on stall_cnt when PIPE_STAGE_BUF_PERF_EN is defined.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,output logic [31:0]               stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  // Handshake decoded from registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;
  pipe_stage_buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .clr(flush), .inc(push), .ptr(wr_ptr)
  );
  pipe_stage_buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .clr(flush), .inc(pop), .ptr(rd_ptr)
  );
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (flush) count <= '0;
    else if (push && !pop) count <= count + 1'b1;
    else if (pop && !push) count <= count - 1'b1;
`ifdef PIPE_STAGE_BUF_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and randomized checks of pipe_stage_buf at DEPTH=2 and DEPTH=3 against queue models.
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic in_ready2, out_valid2, in_ready3, out_valid3;
  logic [31:0] out_data2, out_data3;
  logic [1:0] count2, count3;
  logic [31:0] q2[$], q3[$];
  int unsigned s2, s3;
  int vectors = 0, errors = 0;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall2, stall3;
`endif
  always #5 clk = ~clk;
  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .BUBBLE(NOP_INSTR)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .count(count2)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(stall2)
`endif
  );
  pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .count(count3)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(stall3)
`endif
  );
  task automatic clock();
    bit p2, o2, p3, o3;
    p2 = rst_n && in_valid && q2.size() < 2 && !flush;
    o2 = rst_n && q2.size() != 0 && out_ready && !flush;
    p3 = rst_n && in_valid && q3.size() < 3 && !flush;
    o3 = rst_n && q3.size() != 0 && out_ready && !flush;
    if (rst_n && q2.size() != 0 && !out_ready && !flush && s2 != 32'hFFFF_FFFF) s2++;
    if (rst_n && q3.size() != 0 && !out_ready && !flush && s3 != 32'hFFFF_FFFF) s3++;
    @(posedge clk);
    if (!rst_n || flush) begin
      q2.delete();
      q3.delete();
    end else begin
      if (o2) void'(q2.pop_front());
      if (p2) q2.push_back(in_data);
      if (o3) void'(q3.pop_front());
      if (p3) q3.push_back(in_data);
    end
    #1;
  endtask
  task automatic assert_reset();
    rst_n = 0;
    q2.delete();
    q3.delete();
    s2 = 0;
    s3 = 0;
  endtask
  task automatic test_reset();
    assert_reset();
    in_valid = 1;
    in_data = 32'h77;
    repeat (3) clock();
    vectors++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready2); end
    vectors++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid2); end
    vectors++; if (out_data2 !== NOP_INSTR) begin errors++; $display("FAIL reset_out_data got %h want %h", out_data2, NOP_INSTR); end
    vectors++; if (count2 !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count2); end
    vectors++; if (out_data3 !== 32'h0) begin errors++; $display("FAIL reset_out_data3 got %h want 0", out_data3); end
    rst_n = 1;
    clock();
    vectors++; if (count2 !== 2'd1 || out_data2 !== 32'h77) begin errors++; $display("FAIL first_push count %0d data %h want 1 00000077", count2, out_data2); end
    in_valid = 0;
    flush = 1;
    clock();
    flush = 0;
  endtask
  task automatic test_stream();
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      clock();
      vectors++; if (out_data2 !== vals[i] || count2 !== 2'd1 || out_valid2 !== 1'b1) begin
        errors++; $display("FAIL stream_%0d data %h count %0d want %h 1", i, out_data2, count2, vals[i]);
      end
    end
    in_valid = 0;
    clock();
    vectors++; if (out_valid2 !== 1'b0 || out_data2 !== NOP_INSTR) begin errors++; $display("FAIL stream_drain valid %b data %h want 0 %h", out_valid2, out_data2, NOP_INSTR); end
  endtask
  task automatic test_backpressure();
    logic [31:0] exp [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = exp[i];
      clock();
    end
    vectors++; if (count3 !== 2'd3 || in_ready3 !== 1'b0) begin errors++; $display("FAIL bp_full count %0d ready %b want 3 0", count3, in_ready3); end
    in_data = 32'hD;
    clock();
    vectors++; if (count3 !== 2'd3 || out_data3 !== 32'hA) begin errors++; $display("FAIL bp_refuse count %0d data %h want 3 a", count3, out_data3); end
    out_ready = 1;
    vectors++; if (out_data3 !== exp[0]) begin errors++; $display("FAIL bp_order_0 got %h want %h", out_data3, exp[0]); end
    clock();
    for (int i = 1; i < 4; i++) begin
      vectors++; if (out_data3 !== exp[i] || out_valid3 !== 1'b1) begin errors++; $display("FAIL bp_order_%0d got %h want %h", i, out_data3, exp[i]); end
      if (i == 1) begin
        vectors++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b want 1", in_ready3); end
      end
      clock();
      in_valid = 0;
    end
    vectors++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid3); end
    flush = 1;
    clock();
    flush = 0;
  endtask
  task automatic test_flush();
    out_ready = 0;
    in_valid = 1;
    in_data = 32'h1;
    clock();
    in_data = 32'h2;
    clock();
    vectors++; if (count2 !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d want 2", count2); end
    flush = 1;
    in_data = 32'h55;
    clock();
    flush = 0;
    in_valid = 0;
    vectors++; if (count2 !== 2'd0 || out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || out_data2 !== NOP_INSTR) begin
      errors++; $display("FAIL flush_clear count %0d valid %b ready %b data %h want 0 0 1 %h", count2, out_valid2, in_ready2, out_data2, NOP_INSTR);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      clock();
      vectors++; if (out_valid2 !== 1'b0 || out_data2 === 32'h55) begin errors++; $display("FAIL flush_no_55 valid %b data %h want 0", out_valid2, out_data2); end
    end
  endtask
  task automatic test_async_reset();
    out_ready = 0;
    in_valid = 1;
    in_data = 32'hC0DE;
    repeat (2) clock();
    in_valid = 0;
    vectors++; if (count2 !== 2'd2) begin errors++; $display("FAIL areset_fill got %0d want 2", count2); end
    #2;
    assert_reset();
    #1;
    vectors++; if (count2 !== 2'd0 || out_valid2 !== 1'b0 || count3 !== 2'd0 || out_valid3 !== 1'b0) begin
      errors++; $display("FAIL areset_immediate count %0d valid %b count3 %0d valid3 %b want 0", count2, out_valid2, count3, out_valid3);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      clock();
      flush = 0;
      vectors++; if (count2 !== 2'(q2.size()) || out_valid2 !== (q2.size() != 0) || in_ready2 !== (q2.size() < 2)
                     || out_data2 !== (q2.size() != 0 ? q2[0] : NOP_INSTR)) begin
        errors++; $display("FAIL rand2_%0d count %0d data %h want %0d %h", n, count2, out_data2, q2.size(), q2.size() != 0 ? q2[0] : NOP_INSTR);
      end
      vectors++; if (count3 !== 2'(q3.size()) || out_valid3 !== (q3.size() != 0) || in_ready3 !== (q3.size() < 3)
                     || out_data3 !== (q3.size() != 0 ? q3[0] : 32'h0)) begin
        errors++; $display("FAIL rand3_%0d count %0d data %h want %0d %h", n, count3, out_data3, q3.size(), q3.size() != 0 ? q3[0] : 32'h0);
      end
    end
`ifdef PIPE_STAGE_BUF_PERF_EN
    vectors++; if (stall2 !== s2 || stall3 !== s3) begin errors++; $display("FAIL rand_stall got %0d %0d want %0d %0d", stall2, stall3, s2, s3); end
`endif
  endtask
`ifdef PIPE_STAGE_BUF_PERF_EN
  task automatic test_perf();
    in_valid = 0;
    out_ready = 0;
    flush = 0;
    #2;
    assert_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    vectors++; if (stall2 !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d want 0", stall2); end
    in_valid = 1;
    in_data = 32'h99;
    clock();
    in_valid = 0;
    repeat (7) clock();
    flush = 1;
    clock();
    flush = 0;
    vectors++; if (stall2 !== 32'd7 || stall3 !== 32'd7) begin errors++; $display("FAIL perf_after_flush got %0d %0d want 7", stall2, stall3); end
    clock();
    vectors++; if (stall2 !== 32'd7 || stall2 !== s2) begin errors++; $display("FAIL perf_hold got %0d want 7", stall2); end
  endtask
`endif
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef PIPE_STAGE_BUF_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
